// File: rtl/rc522_spi_responder.sv
// RC522 register-interface SPI slave (mode 0, MSB first).
// Serves a 64x8 register file plus a FIFO behind FIFODataReg. A host push
// port preloads FIFO bytes, and every SPI register write is exposed on a
// one-cycle observe strobe.
//
// Handshake note: there is no ready/backpressure anywhere. host_push is
// accepted every clk it is high, and reg_wr_valid is a single-cycle
// qualifier for reg_wr_addr/reg_wr_data with no ready.
module rc522_spi_responder #(
    parameter int         FIFO_DEPTH = 64,
    parameter logic [7:0] VERSION    = 8'h92
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    input  logic       host_push,
    input  logic [7:0] host_data,
    output logic [6:0] fifo_level,
    output logic       fifo_full,
    output logic       reg_wr_valid,
    output logic [5:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic       busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADDR  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_READ  = 2'd3;

    localparam logic [5:0] A_ERROR      = 6'h06;
    localparam logic [5:0] A_FIFO_DATA  = 6'h09;
    localparam logic [5:0] A_FIFO_LEVEL = 6'h0A;
    localparam logic [5:0] A_VERSION    = 6'h37;

    // synchronizers and edge history
    logic       cs_meta, cs_sync, cs_prev;
    logic       sck_meta, sck_sync, sck_prev;
    logic       mosi_meta, mosi_sync;
    logic [1:0] settle;
    logic       armed;

    // transaction state
    logic [1:0] state;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [6:0] tx_shift;
    logic [5:0] cur_addr;
    logic       pend_rd;
    logic [5:0] pend_addr;

    // storage
    logic [7:0]    regs [64];
    logic [7:0]    mem  [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [6:0]    level;
    logic          ovfl;

    // decoded events
    logic          cs_fall, cs_rise, sck_rise, sck_fall, active;
    logic [7:0]    rx_byte;
    logic          byte_done, spi_wr, spi_push, flush, tx_load, pop_req;
    logic [7:0]    rd_data, load_byte;
    logic          do_pop, spi_ok, host_ok, ovfl_set;
    logic [7:0]    avail, host_need;
    logic [PW-1:0] host_ptr;

    // Two-flop synchronizers. cs resets high so busy is low in reset; the
    // armed flag keeps a transaction already in flight at reset release from
    // being decoded until cs has been seen high after the chain settles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_prev   <= 1'b1;
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_prev  <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
            settle    <= 2'd0;
            armed     <= 1'b0;
        end else begin
            cs_meta   <= cs;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            sck_meta  <= sck;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
            if (settle != 2'd2) settle <= settle + 2'd1;
            if (settle == 2'd2 && cs_sync) armed <= 1'b1;
        end
    end

    // Edge decode and per-clk transaction events.
    always_comb begin
        cs_fall   = armed & cs_prev & ~cs_sync;
        cs_rise   = ~cs_prev & cs_sync;
        sck_rise  = sck_sync & ~sck_prev;
        sck_fall  = ~sck_sync & sck_prev;
        active    = (state != ST_IDLE) && !cs_rise;
        rx_byte   = {rx_shift, mosi_sync};
        byte_done = active && sck_rise && (bit_cnt == 3'd7);
        spi_wr    = byte_done && (state == ST_WRITE);
        spi_push  = spi_wr && (cur_addr == A_FIFO_DATA);
        flush     = spi_wr && (cur_addr == A_FIFO_LEVEL) && rx_byte[7];
        tx_load   = active && sck_fall && (bit_cnt == 3'd0);
        pop_req   = tx_load && pend_rd && (pend_addr == A_FIFO_DATA);
    end

    // Read mux for the pending response byte, evaluated at the tx load.
    always_comb begin
        rd_data = regs[pend_addr];
        case (pend_addr)
            A_FIFO_DATA:  rd_data = (level != 7'd0) ? mem[rd_ptr] : 8'h00;
            A_FIFO_LEVEL: rd_data = {1'b0, level};
            A_ERROR:      rd_data = {3'b000, ovfl, 4'b0000};
            A_VERSION:    rd_data = VERSION;
            default:      rd_data = regs[pend_addr];
        endcase
        load_byte = pend_rd ? rd_data : 8'h00;
    end

    // FIFO admission: a pop frees its slot first, the SPI byte goes ahead of
    // the host byte, and a flush swallows any host push without overflow.
    always_comb begin
        do_pop    = pop_req && (level != 7'd0);
        avail     = 8'(FIFO_DEPTH) - {1'b0, level} + {7'd0, do_pop};
        host_need = spi_push ? 8'd2 : 8'd1;
        spi_ok    = spi_push && (avail >= 8'd1);
        host_ok   = host_push && !flush && (avail >= host_need);
        ovfl_set  = (spi_push && !spi_ok) || (host_push && !flush && !host_ok);
        host_ptr  = spi_ok ? (wr_ptr + PTR_ONE) : wr_ptr;
    end

    // FIFO pointers, occupancy and the sticky BufferOvfl flag.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= 7'd0;
            ovfl   <= 1'b0;
        end else begin
            if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
            wr_ptr <= wr_ptr + PW'(spi_ok) + PW'(host_ok);
            level  <= level - 7'(do_pop) + 7'(spi_ok) + 7'(host_ok);
            if (ovfl_set) ovfl <= 1'b1;
        end
    end

    // FIFO payload storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (spi_ok)  mem[wr_ptr]   <= rx_byte;
        if (host_ok) mem[host_ptr] <= host_data;
    end

    // Plain register storage; special registers are decoded elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
        end else if (spi_wr && cur_addr != A_ERROR && cur_addr != A_FIFO_DATA &&
                     cur_addr != A_FIFO_LEVEL && cur_addr != A_VERSION) begin
            regs[cur_addr] <= rx_byte;
        end
    end

    // Transaction FSM: bit counting, address decode and miso shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            rx_shift  <= 7'd0;
            tx_shift  <= 7'd0;
            miso      <= 1'b0;
            cur_addr  <= 6'd0;
            pend_rd   <= 1'b0;
            pend_addr <= 6'd0;
        end else if (cs_rise) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            tx_shift <= 7'd0;
            miso     <= 1'b0;
            pend_rd  <= 1'b0;
        end else if (cs_fall) begin
            state    <= ST_ADDR;
            bit_cnt  <= 3'd0;
            rx_shift <= 7'd0;
            tx_shift <= 7'd0;
            miso     <= 1'b0;
            pend_rd  <= 1'b0;
        end else if (state != ST_IDLE) begin
            if (sck_rise) begin
                rx_shift <= rx_byte[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    case (state)
                        ST_ADDR: begin
                            cur_addr  <= rx_byte[6:1];
                            pend_addr <= rx_byte[6:1];
                            if (rx_byte[7]) begin
                                state   <= ST_READ;
                                pend_rd <= 1'b1;
                            end else begin
                                state   <= ST_WRITE;
                            end
                        end
                        ST_READ: pend_addr <= rx_byte[6:1];
                        default: ;
                    endcase
                end
            end else if (sck_fall) begin
                if (bit_cnt == 3'd0) begin
                    tx_shift <= load_byte[6:0];
                    miso     <= load_byte[7];
                end else begin
                    tx_shift <= {tx_shift[5:0], 1'b0};
                    miso     <= tx_shift[6];
                end
            end
        end
    end

    // Write-observe strobe, one clk per accepted SPI write byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_wr_valid <= 1'b0;
            reg_wr_addr  <= 6'd0;
            reg_wr_data  <= 8'h00;
        end else begin
            reg_wr_valid <= spi_wr;
            if (spi_wr) begin
                reg_wr_addr <= cur_addr;
                reg_wr_data <= rx_byte;
            end
        end
    end

    assign fifo_level = level;
    assign fifo_full  = (level == 7'(FIFO_DEPTH));
    assign busy       = ~cs_sync;

endmodule

// File: tb/tb_rc522_spi_responder.sv
// Bench for rc522_spi_responder: directed register-map scenarios followed by
// randomized transactions, all scored against a register-map model.
module tb_rc522_spi_responder;

  localparam int DEPTH = 64;
  localparam int HALF  = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cs, sck, mosi, miso;
  logic       host_push;
  logic [7:0] host_data;
  logic [6:0] fifo_level;
  logic       fifo_full, reg_wr_valid, busy;
  logic [5:0] reg_wr_addr;
  logic [7:0] reg_wr_data;

  rc522_spi_responder #(.FIFO_DEPTH(DEPTH), .VERSION(8'h92)) dut (
    .clk(clk), .rst(rst), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso),
    .host_push(host_push), .host_data(host_data),
    .fifo_level(fifo_level), .fifo_full(fifo_full),
    .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard queues
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  logic [13:0] exp_wr_q[$];
  logic [13:0] obs_wr_q[$];
  int          hook_k = 0;
  int          hook_kind = 0;
  logic [7:0]  hook_data = 8'h00;

  // reference model: register map and FIFO contents
  logic [7:0] m_regs [64];
  logic [7:0] m_fifo[$];
  logic       m_ovfl;

  always @(negedge clk) begin
    if (reg_wr_valid === 1'b1) obs_wr_q.push_back({reg_wr_addr, reg_wr_data});
  end

  initial begin
    #900us;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
    m_fifo.delete();
    m_ovfl = 1'b0;
  endtask

  task automatic m_push(input logic [7:0] d);
    if (m_fifo.size() >= DEPTH) m_ovfl = 1'b1;
    else m_fifo.push_back(d);
  endtask

  task automatic m_write(input logic [5:0] a, input logic [7:0] d);
    case (a)
      6'h09: m_push(d);
      6'h0A: if (d[7]) begin m_fifo.delete(); m_ovfl = 1'b0; end
      6'h06, 6'h37: ;
      default: m_regs[a] = d;
    endcase
  endtask

  task automatic m_read(input logic [5:0] a, output logic [7:0] v);
    case (a)
      6'h09: v = (m_fifo.size() == 0) ? 8'h00 : m_fifo.pop_front();
      6'h0A: v = 8'(m_fifo.size());
      6'h06: v = m_ovfl ? 8'h10 : 8'h00;
      6'h37: v = 8'h92;
      default: v = m_regs[a];
    endcase
  endtask

  // Response byte n is the register named by command byte n-1; the falling
  // edge after the last byte still performs a (discarded) read.
  task automatic model_xfer();
    logic       is_rd, prd;
    logic [5:0] a, pa;
    logic [7:0] b, v;
    exp_q.delete();
    exp_q.push_back(8'h00);
    is_rd = 1'b0; prd = 1'b0; a = 6'd0; pa = 6'd0;
    for (int k = 0; k < tx_q.size(); k++) begin
      b = tx_q[k];
      if (k == 0) begin
        a = b[6:1]; is_rd = b[7];
        if (is_rd) begin prd = 1'b1; pa = a; end
      end else if (is_rd) begin
        pa = b[6:1];
      end else begin
        m_write(a, b);
        exp_wr_q.push_back({a, b});
      end
      if (hook_kind == 1 && hook_k == k) m_push(hook_data);
      v = 8'h00;
      if (prd) m_read(pa, v);
      if (k + 1 < tx_q.size()) exp_q.push_back(v);
      if (hook_kind == 2 && hook_k == k) m_push(hook_data);
    end
  endtask

  // driver tasks
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // host push landing in the same clk the DUT acts on an sck edge just driven
  task automatic aligned_host_push();
    wait_n(2);
    host_data = hook_data;
    host_push = 1'b1;
    wait_n(1);
    host_push = 1'b0;
  endtask

  task automatic do_host_push(input logic [7:0] d);
    host_data = d;
    host_push = 1'b1;
    wait_n(1);
    host_push = 1'b0;
    m_push(d);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits, input int hk, output logic [7:0] r);
    logic [7:0] t;
    t = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = b[i];
      wait_n(HALF);
      t[i] = miso;
      sck = 1'b1;
      if (hk == 1 && i == 0) begin aligned_host_push(); wait_n(HALF - 3); end
      else wait_n(HALF);
      sck = 1'b0;
      if (hk == 2 && i == 0) begin aligned_host_push(); wait_n(HALF - 3); end
    end
    r = t;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_wr_count"}, 16'(obs_wr_q.size()), 16'(exp_wr_q.size()));
    for (int i = 0; i < obs_wr_q.size() && i < exp_wr_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 16'(obs_wr_q[i]), 16'(exp_wr_q[i]));
    obs_wr_q.delete();
    exp_wr_q.delete();
  endtask

  task automatic run_xfer(input string tag);
    logic [7:0] rb;
    model_xfer();
    rx_q.delete();
    cs = 1'b0;
    wait_n(HALF);
    chk({tag, "_busy"}, 16'(busy), 16'd1);
    for (int k = 0; k < tx_q.size(); k++) begin
      spi_bits(tx_q[k], 8, (k == hook_k) ? hook_kind : 0, rb);
      rx_q.push_back(rb);
    end
    wait_n(HALF);
    cs = 1'b1;
    wait_n(8);
    chk({tag, "_idle"}, 16'(busy), 16'd0);
    for (int k = 0; k < rx_q.size(); k++)
      chk($sformatf("%s_rx%0d", tag, k), 16'(rx_q[k]), 16'(exp_q[k]));
    check_writes(tag);
    chk({tag, "_level"}, 16'(fifo_level), 16'(m_fifo.size()));
    chk({tag, "_full"}, 16'(fifo_full), 16'(m_fifo.size() == DEPTH));
    hook_kind = 0;
  endtask

  function automatic logic [5:0] rand_addr();
    if ($urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 3))
        0: return 6'h06;
        1: return 6'h09;
        2: return 6'h0A;
        default: return 6'h37;
      endcase
    end
    return 6'($urandom_range(0, 63));
  endfunction

  initial begin
    logic [7:0] rb;
    logic [5:0] a;
    int         n;
    rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    host_push = 1'b0; host_data = 8'h00;
    m_reset();
    wait_n(5);
    rst = 1'b0;
    wait_n(1);
    chk("rst_miso", 16'(miso), 16'd0);
    chk("rst_wr_valid", 16'(reg_wr_valid), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_level", 16'(fifo_level), 16'd0);
    chk("rst_full", 16'(fifo_full), 16'd0);
    wait_n(10);

    // version read
    tx_q = {8'hEE, 8'h00};
    run_xfer("version");
    chk("version_value", 16'(rx_q[1]), 16'h92);

    // write then read back
    tx_q = {8'h02, 8'h0C};
    run_xfer("wr01");
    tx_q = {8'h82, 8'h00};
    run_xfer("rd01");
    chk("rd01_value", 16'(rx_q[1]), 16'h0C);

    // FIFO burst read of a host-loaded UID
    do_host_push(8'hDE); do_host_push(8'hAD); do_host_push(8'hBE); do_host_push(8'hEF);
    wait_n(2);
    chk("uid_level", 16'(fifo_level), 16'd4);
    tx_q = {8'h92, 8'h92, 8'h92, 8'h92, 8'h00};
    run_xfer("burst");
    chk("burst_b4", 16'(rx_q[4]), 16'hEF);
    tx_q = {8'h92, 8'h00};
    run_xfer("pop_empty");

    // overflow then flush
    for (int i = 0; i < DEPTH + 1; i++) do_host_push(8'($urandom));
    wait_n(2);
    chk("ovf_full", 16'(fifo_full), 16'd1);
    tx_q = {8'h8C, 8'h00};
    run_xfer("ovf_err");
    chk("ovf_err_value", 16'(rx_q[1]), 16'h10);
    tx_q = {8'h14, 8'h80};
    run_xfer("flush");
    tx_q = {8'h8C, 8'h00};
    run_xfer("flush_err");

    // abort a write byte after 5 bits
    cs = 1'b0;
    wait_n(HALF);
    spi_bits(8'h02, 8, 0, rb);
    spi_bits(8'hA5, 5, 0, rb);
    wait_n(HALF);
    cs = 1'b1;
    wait_n(8);
    check_writes("abort");
    tx_q = {8'h02, 8'h3C};
    run_xfer("post_abort_wr");
    tx_q = {8'h82, 8'h00};
    run_xfer("post_abort_rd");

    // host push colliding with a FIFODataReg pop at level 2
    do_host_push(8'h11); do_host_push(8'h22);
    tx_q = {8'h92, 8'h00};
    hook_k = 0; hook_kind = 2; hook_data = 8'h33;
    run_xfer("pop_push");
    chk("pop_push_level", 16'(fifo_level), 16'd2);

    // host push colliding with an SPI push at level DEPTH-1
    while (m_fifo.size() < DEPTH - 1) do_host_push(8'($urandom));
    tx_q = {8'h12, 8'h5A};
    hook_k = 1; hook_kind = 1; hook_data = 8'hA5;
    run_xfer("dual_push");
    tx_q = {8'h8C, 8'h00};
    run_xfer("dual_push_err");
    tx_q = {8'h14, 8'h80};
    run_xfer("dual_flush");

    // randomized transactions
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 2))
        0: begin
          a = rand_addr();
          tx_q = {{1'b0, a, 1'($urandom)}};
          n = $urandom_range(1, 3);
          for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
          run_xfer($sformatf("rnd%0d_w", t));
        end
        1: begin
          a = rand_addr();
          tx_q = {{1'b1, a, 1'($urandom)}};
          n = $urandom_range(1, 4);
          for (int i = 0; i < n; i++) tx_q.push_back({1'($urandom), rand_addr(), 1'($urandom)});
          run_xfer($sformatf("rnd%0d_r", t));
        end
        default: begin
          n = $urandom_range(1, 5);
          for (int i = 0; i < n; i++) do_host_push(8'($urandom));
          wait_n(2);
          chk($sformatf("rnd%0d_hlevel", t), 16'(fifo_level), 16'(m_fifo.size()));
        end
      endcase
    end

    // reset in the middle of a write; traffic ignored until cs cycles
    cs = 1'b0;
    wait_n(HALF);
    spi_bits(8'h02, 8, 0, rb);
    rst = 1'b1;
    wait_n(2);
    rst = 1'b0;
    m_reset();
    wait_n(1);
    chk("midrst_level", 16'(fifo_level), 16'd0);
    chk("midrst_miso", 16'(miso), 16'd0);
    spi_bits(8'h02, 8, 0, rb);
    spi_bits(8'h77, 8, 0, rb);
    chk("midrst_rx", 16'(rb), 16'h00);
    wait_n(HALF);
    cs = 1'b1;
    wait_n(8);
    check_writes("midrst");
    tx_q = {8'h82, 8'h00};
    run_xfer("midrst_rd");
    tx_q = {8'h02, 8'h44};
    run_xfer("midrst_wr");
    tx_q = {8'h82, 8'h00};
    run_xfer("midrst_rd2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
